// File: rtl/noc_local_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_local_inject_arbiter
// Description : Packet-level round-robin arbiter sharing the router local (P)
//               injection port among NumReq tile-side requesters. A grant is
//               held from head flit to tail flit, so packets never interleave.
//               One output register stage drives data_p_out/data_void_out and
//               honours the router stop_in.
//               Optional feature macro: NOC_INJECT_ERR_EN adds the err_proto
//               output, a one-cycle pulse flagging framing violations.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_local_inject_arbiter #(
    parameter int NumReq = 4,
    parameter int Width  = 66
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumReq-1:0][Width-1:0]  req_data_in,
    input  logic [NumReq-1:0]             req_void_in,
    output logic [NumReq-1:0]             req_stop_out,
    output logic [Width-1:0]              data_p_out,
    output logic                          data_void_out,
    input  logic                          stop_in
`ifdef NOC_INJECT_ERR_EN
    ,
    output logic                          err_proto
`endif
);

    localparam int         c_PTR_W     = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int         c_HEAD_BIT  = Width - 1;
    localparam int         c_TAIL_BIT  = Width - 2;
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    // Registered state
    logic [0:0]          state_q,     state_d;
    logic [c_PTR_W-1:0]  owner_q,     owner_d;
    logic [c_PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [Width-1:0]    out_flit_q,  out_flit_d;
`ifdef NOC_INJECT_ERR_EN
    logic                err_q,       err_d;
`endif

    // Combinational arbitration signals
    logic                w_can_load;
    logic [NumReq-1:0]   w_eligible;
    logic                w_win_found;
    logic [c_PTR_W-1:0]  w_win_idx;
    logic                w_acc_any;
    logic [c_PTR_W-1:0]  w_acc_idx;
    logic [Width-1:0]    w_acc_flit;

    // Increment an index modulo NumReq (NumReq need not be a power of two).
    function automatic logic [c_PTR_W-1:0] f_inc_wrap(input logic [c_PTR_W-1:0] v);
        if (int'(v) == NumReq - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // State register: output stage, FSM, lock owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
`ifdef NOC_INJECT_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
`ifdef NOC_INJECT_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Round-robin search: first non-void head flit at or after rr_ptr.
    always_comb begin : p_winner
        logic [c_PTR_W:0] v_sum;
        v_sum       = '0;
        w_eligible  = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_eligible[i] = !req_void_in[i] && req_data_in[i][c_HEAD_BIT];
        end
        for (int k = 0; k < NumReq; k++) begin
            v_sum = {1'b0, rr_ptr_q} + (c_PTR_W + 1)'(k);
            if (v_sum >= (c_PTR_W + 1)'(NumReq)) begin
                v_sum = v_sum - (c_PTR_W + 1)'(NumReq);
            end
            if (!w_win_found && w_eligible[v_sum[c_PTR_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = v_sum[c_PTR_W-1:0];
            end
        end
    end

    // Output decode: which requester (if any) is accepted this cycle.
    always_comb begin
        w_can_load   = !out_valid_q || !stop_in;
        w_acc_any    = 1'b0;
        w_acc_idx    = '0;
        req_stop_out = '1;
        if (!rst && w_can_load) begin
            if (state_q == c_ST_IDLE) begin
                if (w_win_found) begin
                    w_acc_any = 1'b1;
                    w_acc_idx = w_win_idx;
                end
            end else if (!req_void_in[owner_q]) begin
                // A void cycle from the owner simply holds the lock.
                w_acc_any = 1'b1;
                w_acc_idx = owner_q;
            end
        end
        if (w_acc_any) begin
            req_stop_out[w_acc_idx] = 1'b0;
        end
        w_acc_flit    = req_data_in[w_acc_idx];
        data_p_out    = out_flit_q;
        data_void_out = !out_valid_q;
    end

    // Next-state logic: load the output stage and advance the packet lock.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        if (w_can_load) begin
            // Refill in the same cycle the held flit leaves: no bubble.
            out_valid_d = w_acc_any;
            if (w_acc_any) begin
                out_flit_d = w_acc_flit;
            end
        end
        if (w_acc_any) begin
            if (w_acc_flit[c_TAIL_BIT]) begin
                state_d  = c_ST_IDLE;
                rr_ptr_d = f_inc_wrap(w_acc_idx);
            end else if (state_q == c_ST_IDLE) begin
                state_d = c_ST_LOCKED;
                owner_d = w_acc_idx;
            end
        end
    end

`ifdef NOC_INJECT_ERR_EN
    // Framing check: body flit offered while idle, or a second head from the owner.
    always_comb begin
        err_d = 1'b0;
        if (state_q == c_ST_IDLE) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!req_void_in[i] && !req_data_in[i][c_HEAD_BIT]) begin
                    err_d = 1'b1;
                end
            end
        end else if (!req_void_in[owner_q] && req_data_in[owner_q][c_HEAD_BIT]) begin
            err_d = 1'b1;
        end
    end

    assign err_proto = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_local_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_local_inject_arbiter
// Description : Randomised + directed bench for noc_local_inject_arbiter with a
//               packet-level reference model and an output scoreboard.
//               Build with NOC_INJECT_ERR_EN defined to cover err_proto.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_local_inject_arbiter;

    localparam int N = 4;
    localparam int W = 66;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0][W-1:0]   req_data_in;
    logic [N-1:0]          req_void_in;
    logic [N-1:0]          req_stop_out;
    logic [W-1:0]          data_p_out;
    logic                  data_void_out;
    logic                  stop_in;
`ifdef NOC_INJECT_ERR_EN
    logic                  err_proto;
`endif

    noc_local_inject_arbiter #(.NumReq(N), .Width(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_data_in   (req_data_in),
        .req_void_in   (req_void_in),
        .req_stop_out  (req_stop_out),
        .data_p_out    (data_p_out),
        .data_void_out (data_void_out),
        .stop_in       (stop_in)
`ifdef NOC_INJECT_ERR_EN
        ,
        .err_proto     (err_proto)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester flit queues feeding the drivers.
    logic [W-1:0] fq [N][$];
    bit           hold_void [N];
    int           void_pct;
    int           stop_pct;
    bit           stop_force;

    // Reference model state and scoreboard of flits expected downstream.
    bit           m_out_valid;
    bit           m_locked;
    int           m_owner;
    int           m_rr;
    bit           m_err;
    logic [W-1:0] sb [$];

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: packet-level round robin evaluated on the pre-edge inputs.
    always @(negedge clk) begin : p_model
        int  acc;
        int  idx;
        bit  cl;
        bit  viol;
        logic [N-1:0] exp_stop;
        if (rst) begin
            check("req_stop_in_reset", W'(req_stop_out), W'({N{1'b1}}));
            m_out_valid = 0;
            m_locked    = 0;
            m_owner     = 0;
            m_rr        = 0;
            m_err       = 0;
            sb.delete();
        end else begin
            check("data_void_out", W'(data_void_out), W'(!m_out_valid));
`ifdef NOC_INJECT_ERR_EN
            check("err_proto", W'(err_proto), W'(m_err));
`endif
            cl  = !m_out_valid || !stop_in;
            acc = -1;
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (acc < 0 && !req_void_in[idx] && req_data_in[idx][W-1]) acc = idx;
                end
            end else if (!req_void_in[m_owner]) begin
                acc = m_owner;
            end
            if (!cl) acc = -1;
            exp_stop = '1;
            if (acc >= 0) exp_stop[acc] = 1'b0;
            check("req_stop_out", W'(req_stop_out), W'(exp_stop));
            viol = 0;
            if (!m_locked) begin
                for (int i = 0; i < N; i++)
                    if (!req_void_in[i] && !req_data_in[i][W-1]) viol = 1;
            end else if (!req_void_in[m_owner] && req_data_in[m_owner][W-1]) begin
                viol = 1;
            end
            m_err = viol;
            if (cl) m_out_valid = (acc >= 0);
            if (acc >= 0) begin
                sb.push_back(req_data_in[acc]);
                if (req_data_in[acc][W-2]) begin
                    m_locked = 0;
                    m_rr     = (acc + 1) % N;
                end else if (!m_locked) begin
                    m_locked = 1;
                    m_owner  = acc;
                end
            end
        end
    end

    // Monitor: every presented flit must be the scoreboard head; pop on transfer.
    always @(negedge clk) begin : p_monitor
        if (!rst && !data_void_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got %h expected no flit", data_p_out);
            end else begin
                check("data_p_out", data_p_out, sb[0]);
                if (!stop_in) void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus: retire accepted flits, then drive the next inputs.
    task automatic step();
        bit           acc [N];
        logic [W-1:0] junk;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            acc[i] = !rst && !req_void_in[i] && !req_stop_out[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        for (int i = 0; i < N; i++) begin
            if (fq[i].size() > 0 && !hold_void[i] && $urandom_range(99) >= void_pct) begin
                req_void_in[i] = 1'b0;
                req_data_in[i] = fq[i][0];
            end else begin
                junk = W'({$urandom, $urandom, $urandom});
                req_void_in[i] = 1'b1;
                req_data_in[i] = junk;
            end
        end
        stop_in = stop_force || ($urandom_range(99) < stop_pct);
    endtask

    task automatic push_pkt(input int r, input int len);
        for (int k = 0; k < len; k++)
            fq[r].push_back({(k == 0), (k == len - 1), $urandom, $urandom});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        for (int i = 0; i < N; i++) begin
            fq[i].delete();
            hold_void[i] = 0;
        end
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int  cnt;
        bit  busy;
        cnt  = 0;
        busy = 1;
        while (busy && cnt < 400) begin
            step();
            cnt++;
            busy = (sb.size() > 0);
            for (int i = 0; i < N; i++) if (fq[i].size() > 0) busy = 1;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d flits pending expected 0", sb.size());
        end
    endtask

    initial begin : p_stim
        logic [W-1:0] f_exp;
        logic [W-1:0] held;
        rst         = 1'b1;
        req_void_in = '1;
        req_data_in = '0;
        stop_in     = 1'b0;
        void_pct    = 0;
        stop_pct    = 0;
        stop_force  = 0;
        for (int i = 0; i < N; i++) hold_void[i] = 0;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        #1;
        check("idle_void", W'(data_void_out), W'(1'b1));
        check("idle_data", data_p_out, '0);
        check("idle_stop", W'(req_stop_out), W'({N{1'b1}}));

        // Two 3-flit packets, then all-single flits: first grant must be req 3.
        push_pkt(0, 3);
        push_pkt(2, 3);
        step();
        drain();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 1);
        f_exp = fq[3][0];
        step();
        step();
        #1;
        check("rr_after_pkts", data_p_out, f_exp);
        drain();

        // After reset, continuous singles start from requester 0.
        do_reset();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 1);
        f_exp = fq[0][0];
        step();
        step();
        #1;
        check("rr_from_reset", data_p_out, f_exp);
        drain();

        // Backpressure for 5 cycles mid-packet.
        push_pkt(1, 4);
        step();
        step();
        stop_force = 1;
        step();
        held = data_p_out;
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            check("held_stable", data_p_out, held);
        end
        stop_force = 0;
        drain();

        // Owner goes void while another requester offers a head.
        push_pkt(1, 4);
        step();
        step();
        hold_void[1] = 1;
        push_pkt(0, 1);
        repeat (3) step();
        hold_void[1] = 0;
        drain();

        // Body flit in IDLE for a single cycle: rejected, flagged once.
        fq[3].push_back({2'b00, $urandom, $urandom});
        step();
        fq[3].delete();
        repeat (4) step();

        // Second head inside a locked packet is still forwarded.
        fq[0].push_back({2'b10, $urandom, $urandom});
        fq[0].push_back({2'b10, $urandom, $urandom});
        fq[0].push_back({2'b01, $urandom, $urandom});
        step();
        drain();

        // Reset mid-packet drops the lock and the held flit.
        push_pkt(2, 4);
        repeat (3) step();
        do_reset();
        #1;
        check("void_after_reset", W'(data_void_out), W'(1'b1));
        drain();

        // Randomised traffic with voids and backpressure.
        void_pct = 20;
        stop_pct = 30;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (fq[i].size() < 2 && $urandom_range(3) == 0)
                    push_pkt(i, int'($urandom_range(4, 1)));
            step();
        end
        void_pct = 0;
        stop_pct = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/noc_local_inject_arbiter.md
# noc_local_inject_arbiter

Packet-level round-robin arbiter that shares the local (P) injection port of one lookahead router among `NumReq` tile-side requesters. It grants one requester at a time and holds that grant from the head flit through the tail flit, so packets never interleave on the router input. Output flits pass through one register stage that drives the router's `data_p_in` / `data_void_in[P]` and obeys the router's `stop_out[P]`. The block sits between the tile's socket queues and the router, one instance per NoC plane.

## Interface
- `NumReq`, default 4: number of requesters, range 2..8.
- `Width`, default 66: flit width including the 2-bit preamble. Bit Width-1 is head and bit Width-2 is tail; a flit with both set is a single-flit packet.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_data_in`  in  NumReq x Width  flit offered by each requester.
- `req_void_in`  in  NumReq  1 = requester i offers no flit this cycle.
- `req_stop_out`  out  NumReq  1 = requester i's flit is not accepted this cycle.
- `data_p_out`  out  Width  flit to the router local input.
- `data_void_out`  out  1  1 = no flit on `data_p_out`.
- `stop_in`  in  1  router local-port stop; 1 = the router does not take the flit this cycle.
- `err_proto`  out  1  present only with `NOC_INJECT_ERR_EN`; see Configuration.

## Operation
Handshake rules (same-cycle valid/ready semantics on both sides):
- Downstream transfer: `data_void_out`=0 and `stop_in`=0.
- Upstream accept of requester i: `req_void_in[i]`=0 and `req_stop_out[i]`=0.

Output register:
- State is `out_valid` and `out_flit`.
- `can_load` = !`out_valid` || !`stop_in`. This gives full throughput: a new flit loads in the same cycle the held flit leaves.

State machine, IDLE / LOCKED(owner):
- **IDLE:**
  - Eligible requesters are those with `req_void_in[i]`=0 and a head bit of 1.
  - The winner is the first eligible index at or after the round-robin pointer `rr_ptr`, wrapping modulo NumReq.
  - If `can_load`=1, the winner's flit is accepted.
  - If that flit's tail bit = 1: stay in IDLE and set `rr_ptr` = winner+1 mod NumReq.
  - Otherwise: go to LOCKED(winner).
- **LOCKED(o):**
  - Only requester o can be accepted, whenever `can_load`=1.
  - Acceptance of o's tail flit returns the FSM to IDLE and sets `rr_ptr` = o+1 mod NumReq.
  - A void cycle from o holds the lock; no other requester is served.

Stop outputs:
- `req_stop_out[i]` = 0 only for the requester being accepted this cycle.
- All other bits are 1, including requesters offering non-head flits while in IDLE.

Reset values:
- `out_valid`=0, so `data_void_out`=1.
- `data_p_out`=0.
- FSM=IDLE, `rr_ptr`=0.
- `req_stop_out` is all 1 while `rst`=1.
- `err_proto`=0.

## Timing
- Latency: a flit accepted in cycle t appears on `data_p_out` in cycle t+1.
- Throughput: one flit per cycle while `stop_in`=0.
- Backpressure: a held flit stays stable on `data_p_out` until it transfers. When `stop_in`=1 and `out_valid`=1, every `req_stop_out` bit is 1 in the same cycle.
- Arbitration cost: none beyond the single register stage. A head flit can be accepted in the cycle after the previous tail was accepted; there is no bubble.
- Simultaneous heads from all requesters: grant order is `rr_ptr`, `rr_ptr`+1, … with wrap-around from NumReq-1 to 0.
- Reset mid-packet: the lock is dropped and the held flit is discarded. A truncated packet reaching the router is the system's responsibility; the block performs no recovery.

## Configuration
- `NOC_INJECT_ERR_EN` defined:
  - Adds the `err_proto` output.
  - `err_proto` is registered and pulses 1 for one cycle after either protocol violation:
    - in IDLE, a non-void requester presents a flit with head=0;
    - in LOCKED(o), o presents a head=1 flit that is not its first flit.
  - The offending flit is still handled per the FSM: rejected in IDLE, forwarded in LOCKED.
- `NOC_INJECT_ERR_EN` undefined: the port and its logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset then idle, all `req_void_in`=1 → `data_void_out`=1, `data_p_out`=0, `req_stop_out`=4'b1111.
- Requesters 0 and 2 each offer a 3-flit packet, `stop_in`=0 → flits 0H,0B,0T,2H,2B,2T appear on cycles 1–6 with no interleaving; `rr_ptr`=3 afterwards.
- All four requesters offer single-flit packets continuously → grant order 0,1,2,3,0, one flit per cycle.
- Requester 1 is mid-packet and `stop_in` is held at 1 for 5 cycles → `data_p_out` stays stable, `req_stop_out`=1111, and the packet resumes with no loss or duplication.
- Requester 1 is LOCKED and goes void for 3 cycles while requester 0 offers a head → requester 0 stays stopped until requester 1's tail is accepted.
- With `NOC_INJECT_ERR_EN`, requester 3 offers a body flit in IDLE → it is rejected and `err_proto`=1 for exactly one cycle.
